// File: rtl/ppu_pkg.sv
// Shared types and widths for the ppu tile sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppu_pkg;

  localparam int ROWS      = 16;
  localparam int ADDR_W    = 6;
  localparam int PSUM_W    = 384;
  localparam int OUT_W     = 128;
  localparam int ROW_CNT_W = $clog2(ROWS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DRAIN     = 3'd2,
    WAIT_DONE = 3'd3,
    RESULT    = 3'd4
  } state_t;

endpackage

// File: rtl/ppu_row_streamer.sv
// Streams ROWS consecutive accumulator rows (address wraps) and forms the ppu row strobe.
// Latency: acc_rd_en one cycle after start; ppu_valid one cycle after acc_rd_en.
// Backpressure: none; the ppu accepts one row per cycle once started.
module ppu_row_streamer
  import ppu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  output logic              ppu_valid,
  output logic              stream_last
);

  logic [ROW_CNT_W-1:0] row_cnt;

  // The read issued this cycle is the final row of the tile.
  assign stream_last = acc_rd_en && (row_cnt == ROW_CNT_W'(ROWS - 1));

  // Row counter, wrapping address generator and the read-to-ppu delay stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_rd_en   <= 1'b0;
      acc_rd_addr <= '0;
      row_cnt     <= '0;
      ppu_valid   <= 1'b0;
    end else begin
      ppu_valid <= acc_rd_en;
      if (start) begin
        acc_rd_en   <= 1'b1;
        acc_rd_addr <= base;
        row_cnt     <= '0;
      end else if (acc_rd_en) begin
        if (stream_last) begin
          acc_rd_en <= 1'b0;
        end else begin
          // Natural overflow of the ADDR_W-bit register gives the 63 -> 0 wrap.
          acc_rd_addr <= acc_rd_addr + 1'b1;
          row_cnt     <= row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ppu_tile_sequencer.sv
// Sequences one 16-row tile from the accumulator buffer through the ppu and returns its result.
// Latency: accept to res_valid = ROWS + 2 + ppu processing + 1 cycles.
// Backpressure: res_valid holds with stable res_data until res_ready; no command is taken meanwhile.
module ppu_tile_sequencer
  import ppu_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [7:0]        cmd_scale,
  input  logic [7:0]        cmd_bias,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  input  logic [PSUM_W-1:0] acc_rd_data,
  output logic [PSUM_W-1:0] ppu_partial_sum,
  output logic              ppu_valid,
  output logic [7:0]        ppu_scale,
  output logic [7:0]        ppu_bias,
  input  logic              ppu_done,
  input  logic [OUT_W-1:0]  ppu_output_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       tile_count
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  logic            accept;
  logic            stream_last;
  logic            ppu_done_q;
  logic            done_evt;
  logic [WD_W-1:0] wd_cnt;

  assign accept   = cmd_valid & cmd_ready;
  // Only a fresh rising edge counts, so a level left high by the previous tile is ignored.
  assign done_evt = ppu_done & ~ppu_done_q;
  // Rows outside the valid window are zeroed so the ppu never sees stale buffer data.
  assign ppu_partial_sum = ppu_valid ? acc_rd_data : '0;

  ppu_row_streamer u_streamer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept),
    .base        (cmd_base_addr),
    .acc_rd_en   (acc_rd_en),
    .acc_rd_addr (acc_rd_addr),
    .ppu_valid   (ppu_valid),
    .stream_last (stream_last)
  );

  // Delayed copy of ppu_done for rising-edge detection, tracked in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_done_q <= 1'b0;
    end else begin
      ppu_done_q <= ppu_done;
    end
  end

  // Tile FSM with watchdog, result capture and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      ppu_scale   <= '0;
      ppu_bias    <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      tile_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ppu_scale <= cmd_scale;
            ppu_bias  <= cmd_bias;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (stream_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done edge in the final watchdog cycle still produces a result.
          if (done_evt) begin
            res_data  <= ppu_output_data;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            tile_count <= tile_count + 16'd1;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_tile_sequencer.sv
// Scoreboard bench for ppu_tile_sequencer: stimulus pushes expectations, a negedge monitor checks them.
// Latency: n/a.
// Backpressure: res_ready is stalled on selected tiles.
module tb_ppu_tile_sequencer;

  localparam int ROWS = 16;

  typedef struct {
    logic [383:0] data;
    logic [7:0]   scale;
    logic [7:0]   bias;
  } row_t;

  typedef struct {
    logic [127:0] data;
    int           rise;
    int           len;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_base_addr;
  logic [7:0]   cmd_scale;
  logic [7:0]   cmd_bias;
  logic         acc_rd_en;
  logic [5:0]   acc_rd_addr;
  logic [383:0] acc_rd_data;
  logic [383:0] ppu_partial_sum;
  logic         ppu_valid;
  logic [7:0]   ppu_scale;
  logic [7:0]   ppu_bias;
  logic         ppu_done;
  logic [127:0] ppu_output_data;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  tile_count;

  ppu_tile_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_base_addr   (cmd_base_addr),
    .cmd_scale       (cmd_scale),
    .cmd_bias        (cmd_bias),
    .acc_rd_en       (acc_rd_en),
    .acc_rd_addr     (acc_rd_addr),
    .acc_rd_data     (acc_rd_data),
    .ppu_partial_sum (ppu_partial_sum),
    .ppu_valid       (ppu_valid),
    .ppu_scale       (ppu_scale),
    .ppu_bias        (ppu_bias),
    .ppu_done        (ppu_done),
    .ppu_output_data (ppu_output_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .tile_count      (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator buffer model: registered read, data valid one cycle after the strobe.
  logic [383:0] mem [64];
  always @(posedge clk) if (acc_rd_en) acc_rd_data <= mem[acc_rd_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Expectation queues, filled by stimulus and drained by the monitor.
  logic [5:0] addr_q [$];
  int         first_q [$];
  row_t       row_q [$];
  res_t       res_q [$];
  int         exp_tiles = 0;

  // Monitor state.
  bit   en_prev = 0, pv_prev = 0, rv_prev = 0, have_cur = 0;
  int   en_run = 0, pv_run = 0, rv_run = 0;
  row_t mon_row;
  res_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      addr_q.delete(); first_q.delete(); row_q.delete(); res_q.delete();
      exp_tiles = 0; en_prev = 0; pv_prev = 0; rv_prev = 0; have_cur = 0;
      en_run = 0; pv_run = 0; rv_run = 0;
    end else begin
      check("tile_count", tile_count, exp_tiles);
      // Accumulator reads: start cycle, address order, burst length.
      if (acc_rd_en) begin
        if (!en_prev) begin
          if (first_q.size() == 0) fail_now("unexpected_read_start");
          else check("read_start_cycle", cyc, first_q.pop_front());
        end
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else check("acc_rd_addr", acc_rd_addr, addr_q.pop_front());
        en_run++;
      end else if (en_prev) begin
        check("read_burst_len", en_run, ROWS);
        en_run = 0;
      end
      en_prev = acc_rd_en;
      // Rows into the ppu.
      if (ppu_valid) begin
        if (row_q.size() == 0) fail_now("unexpected_ppu_valid");
        else begin
          mon_row = row_q.pop_front();
          check("ppu_partial_sum", ppu_partial_sum, mon_row.data);
          check("ppu_scale", ppu_scale, mon_row.scale);
          check("ppu_bias", ppu_bias, mon_row.bias);
        end
        pv_run++;
      end else begin
        check("partial_sum_idle_zero", ppu_partial_sum, 0);
        if (pv_prev) check("ppu_valid_run", pv_run, ROWS);
        pv_run = 0;
      end
      pv_prev = ppu_valid;
      // Result handshake.
      if (res_valid) begin
        if (!rv_prev) begin
          rv_run = 0;
          if (res_q.size() == 0) begin
            fail_now("unexpected_res_valid");
            have_cur = 0;
          end else begin
            cur = res_q.pop_front();
            have_cur = 1;
            check("res_valid_rise_cycle", cyc, cur.rise);
          end
        end
        rv_run++;
        check("cmd_ready_in_result", cmd_ready, 0);
        if (have_cur) check("res_data", res_data, cur.data);
        if (res_ready) begin
          if (have_cur) check("res_valid_hold_len", rv_run, cur.len);
          exp_tiles = (exp_tiles + 1) % 65536;
        end
      end
      rv_prev = res_valid && !res_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and queue its read/row expectations; a returns the accepting edge.
  task automatic issue_cmd(input logic [5:0] base, output int a);
    logic [7:0] sc, bi;
    logic [5:0] ad;
    int guard;
    sc = 8'($urandom);
    bi = 8'($urandom);
    guard = 0;
    while (!cmd_ready && guard < 2000) begin step(); guard++; end
    if (!cmd_ready) fail_now("wait_cmd_ready");
    for (int k = 0; k < ROWS; k++) begin
      ad = base + 6'(k);
      addr_q.push_back(ad);
      row_q.push_back('{mem[ad], sc, bi});
    end
    cmd_valid = 1; cmd_base_addr = base; cmd_scale = sc; cmd_bias = bi;
    step();
    a = cyc;
    cmd_valid = 0;
    first_q.push_back(a);
  endtask

  // Full tile: delay counts cycles after DRAIN before ppu_done rises; stall = cycles res_ready stays low.
  task automatic run_tile(input logic [5:0] base, input int delay, input int stall, input bit pre_high);
    int a, guard;
    res_t r;
    if (pre_high) ppu_done = 1;
    res_ready = (stall == 0);
    issue_cmd(base, a);
    if (pre_high) begin
      repeat (ROWS + 20) step();
      check("held_done_no_result", res_valid, 0);
      check("held_done_still_busy", busy, 1);
      ppu_done = 0;
      step();
    end else begin
      repeat (ROWS + delay) step();
    end
    ppu_done = 1;
    ppu_output_data = {$urandom, $urandom, $urandom, $urandom};
    r.data = ppu_output_data;
    r.rise = cyc + 1;
    r.len  = stall + 1;
    res_q.push_back(r);
    guard = 0;
    while (!res_valid && guard < 20) begin step(); guard++; end
    if (!res_valid) fail_now("wait_res_valid");
    ppu_done = 0;
    if (stall > 0) begin
      cmd_valid = 1; cmd_base_addr = 6'($urandom);
      repeat (stall) step();
      cmd_valid = 0;
      res_ready = 1;
    end
    step();
  endtask

  int a_to, guard_to, a_rs;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {12{$urandom}};
    rst_n = 0; cmd_valid = 0; cmd_base_addr = 0; cmd_scale = 0; cmd_bias = 0;
    acc_rd_data = 0; ppu_done = 0; ppu_output_data = 0; res_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_acc_rd_en", acc_rd_en, 0);
    check("rst_ppu_valid", ppu_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ppu_scale", ppu_scale, 0);
    rst_n = 1;
    step();

    // Directed: base 0, done 40 cycles after DRAIN.
    run_tile(6'h00, 40, 0, 0);
    check("tile_count_first", tile_count, 1);
    // Address wrap 0x3A..0x3F, 0x00..0x09.
    run_tile(6'h3A, 5, 0, 0);
    // ppu_done already high at accept.
    run_tile(6'h10, 1, 0, 1);

    // Watchdog: ppu never finishes.
    issue_cmd(6'h21, a_to);
    guard_to = 0;
    while (!timeout_err && guard_to < 1200) begin step(); guard_to++; end
    if (!timeout_err) fail_now("wait_timeout_err");
    check("timeout_cycle", cyc, a_to + ROWS + 1 + 1024);
    check("timeout_back_idle", cmd_ready, 1);
    check("timeout_not_busy", busy, 0);
    step();
    check("timeout_sticky", timeout_err, 1);

    // Good tile after timeout, with a 7-cycle consumer stall.
    run_tile(6'h07, 3, 7, 0);
    check("tile_count_after_stall", tile_count, 4);

    // Reset during FETCH row 5.
    issue_cmd(6'h30, a_rs);
    repeat (5) step();
    #2 rst_n = 0;
    #1;
    check("mid_rst_acc_rd_en", acc_rd_en, 0);
    check("mid_rst_ppu_valid", ppu_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tile_count", tile_count, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    check("mid_rst_ppu_scale", ppu_scale, 0);
    check("mid_rst_ppu_bias", ppu_bias, 0);
    check("mid_rst_partial_sum", ppu_partial_sum, 0);
    step();
    step();
    rst_n = 1;
    step();
    run_tile(6'h05, 2, 0, 0);

    // Randomized tiles.
    for (int t = 0; t < 20; t++) begin
      run_tile(6'($urandom), $urandom_range(1, 60), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    repeat (5) step();
    check("addr_q_drained", addr_q.size(), 0);
    check("row_q_drained", row_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
